mux2_rr_packet_arbiter: RTL and testbench

//   Upstream controller for the 2:1 multiplexer: arbitrates two valid/ready packet streams.

---
 rtl/mux2_rr_packet_arbiter_pkg.sv | 8 +
 rtl/mux2to1.sv | 8 +
 rtl/mux2_rr_packet_arbiter.sv | 68 ++++++
 tb/tb_mux2_rr_packet_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mux2_rr_packet_arbiter_pkg.sv
// mux_pkg: shared state and channel encodings for the round-robin packet arbiter.
package mux_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  typedef enum logic {S_IDLE = ST_IDLE, S_BUSY = ST_BUSY} state_t;
endpackage

// File: rtl/mux2to1.sv
// mux2to1: single-bit 2:1 multiplexer slice, Y = X[sel].
module mux2to1 (
  input  logic [1:0] X,
  input  logic       sel,
  output logic       Y
);
  assign Y = sel ? X[1] : X[0];
endmodule

// File: rtl/mux2_rr_packet_arbiter.sv
// mux2_rr_packet_arbiter: round-robin, packet-locked arbiter driving mux2to1 slices
// into a one-deep registered output stage with valid/ready back-pressure.
module mux2_rr_packet_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        in_valid,
  input  logic [1:0]        in_last,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic [1:0]        in_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_last,
  input  logic              out_ready
);
  state_t state, state_nx;
  logic owner, last_grant, load, cand, acc;
  logic [DATA_W-1:0] mux_out;
  for (genvar i = 0; i < DATA_W; i++) begin : g_slice
    mux2to1 u_mux (.X({in_data1[i], in_data0[i]}), .sel(sel), .Y(mux_out[i]));
  end
  // A locked owner is never pre-empted, even while it stalls.
  always_comb begin
    load = !out_valid | out_ready;
    cand = state == S_BUSY ? owner :
           in_valid == 2'b11 ? ~last_grant :
           in_valid[1] ? CH1 :
           in_valid[0] ? CH0 : last_grant;
    sel = cand;
    in_ready = (load & in_valid[cand]) ? (cand ? 2'b10 : 2'b01) : 2'b00;
    acc = |in_ready;
    state_nx = acc ? (in_last[cand] ? S_IDLE : S_BUSY) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      owner <= CH0;
      last_grant <= CH1;
    end else begin
      state <= state_nx;
      if (acc) begin
        owner <= cand;
        last_grant <= cand;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= 1'b0;
      out_last <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data <= mux_out;
      out_src <= cand;
      out_last <= in_last[cand];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux2_rr_packet_arbiter.sv
// tb_mux2_rr_packet_arbiter: directed stimulus with a scoreboard queue of expected output beats.
module tb_mux2_rr_packet_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] in_valid = 2'b00;
  logic [1:0] in_last = 2'b00;
  logic [7:0] in_data0 = 8'h00;
  logic [7:0] in_data1 = 8'h00;
  logic [1:0] in_ready;
  logic sel, out_valid, out_src, out_last;
  logic [7:0] out_data;
  logic out_ready = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [9:0] q[$];
  always #5 clk = ~clk;
  mux2_rr_packet_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_ready(out_ready)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // Drives one cycle; when a grant is expected the accepted beat is queued as {src,last,data}.
  task automatic cyc(input logic [1:0] v, input logic [1:0] l, input logic [7:0] d0,
                     input logic [7:0] d1, input logic ordy, input logic [1:0] er, input logic es);
    @(posedge clk);
    #1;
    in_valid = v;
    in_last = l;
    in_data0 = d0;
    in_data1 = d1;
    out_ready = ordy;
    if (er == 2'b01) q.push_back({1'b0, l[0], d0});
    if (er == 2'b10) q.push_back({1'b1, l[1], d1});
    #2;
    chk("in_ready", {30'd0, in_ready}, {30'd0, er});
    chk("sel", {31'd0, sel}, {31'd0, es});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [9:0] e;
    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", {22'd0, out_src, out_last, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("out_beat", {22'd0, out_src, out_last, out_data}, {22'd0, e});
          end
        end
      end
    join_none
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_src", {31'd0, out_src}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // single ch0 beat
    cyc(2'b01, 2'b01, 8'hA5, 8'h00, 1'b1, 2'b01, 1'b0);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", {24'd0, out_data}, 32'hA5);
    // both channels single-beat every cycle: strict alternation
    for (int i = 0; i < 5; i++)
      cyc(2'b11, 2'b11, 8'h10 + 8'(i), 8'h20 + 8'(i), 1'b1,
          (i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0));
    // ch0 3-beat packet holds the lock against a waiting ch1
    cyc(2'b11, 2'b10, 8'h11, 8'h44, 1'b1, 2'b01, 1'b0);
    cyc(2'b11, 2'b10, 8'h22, 8'h44, 1'b1, 2'b01, 1'b0);
    cyc(2'b11, 2'b11, 8'h33, 8'h44, 1'b1, 2'b01, 1'b0);
    cyc(2'b11, 2'b11, 8'h55, 8'h44, 1'b1, 2'b10, 1'b1);
    cyc(2'b01, 2'b01, 8'h55, 8'h00, 1'b1, 2'b01, 1'b0);
    // back-pressure: one beat held stable, nothing accepted while full
    cyc(2'b01, 2'b01, 8'h60, 8'h00, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b01, 2'b01, 8'h61, 8'h00, 1'b0, 2'b00, 1'b0);
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_data", {24'd0, out_data}, 32'h60);
      chk("t4_hold_last", {31'd0, out_last}, 32'd1);
    end
    cyc(2'b01, 2'b01, 8'h61, 8'h00, 1'b1, 2'b01, 1'b0);
    cyc(2'b01, 2'b01, 8'h62, 8'h00, 1'b1, 2'b01, 1'b0);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0);
    // ch1 owner stalls mid-packet; ch0 must not be granted
    cyc(2'b10, 2'b00, 8'h00, 8'h70, 1'b1, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(2'b01, 2'b01, 8'h99, 8'h00, 1'b1, 2'b00, 1'b1);
    cyc(2'b11, 2'b11, 8'h99, 8'h71, 1'b1, 2'b10, 1'b1);
    cyc(2'b01, 2'b01, 8'h99, 8'h00, 1'b1, 2'b01, 1'b0);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0);
    // reset mid-packet discards the held beat and restarts at ch0
    cyc(2'b10, 2'b00, 8'h00, 8'h80, 1'b1, 2'b10, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1);
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2'b11, 2'b11, 8'hC0, 8'hC1, 1'b1, 2'b01, 1'b0);
    cyc(2'b10, 2'b11, 8'hC0, 8'hC1, 1'b1, 2'b10, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
